// File: rtl/pc_sequencer.sv
// Program sequencer: fetch/execute phase toggle, loadable program counter and
// a small return-address stack for CALL/RET, with a sticky stack error flag.
module pc_sequencer #(
   parameter int                ADDR_W      = 12,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic                               inc,
   input  logic                               load,
   input  logic                               call,
   input  logic                               ret,
   input  logic [ADDR_W-1:0]                  load_value,
   output logic [ADDR_W-1:0]                  pc,
   output logic                               phase,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               stack_err
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = $clog2(STACK_DEPTH);

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
   logic [ADDR_W-1:0]   pc_plus1;
   logic [IDX_W-1:0]    push_idx;
   logic [IDX_W-1:0]    pop_idx;
   logic                do_push;

   // Any valid slot index is below STACK_DEPTH, so it fits in IDX_W bits.
   assign pc_plus1    = pc + ADDR_W'(1);
   assign push_idx    = IDX_W'(sp);
   assign pop_idx     = IDX_W'(sp - SP_W'(1));
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign phase       = state;

   // ret outranks call, so a push happens only when call wins arbitration.
   assign do_push = !rst && enable && (state == EXEC) && !ret && call && !stack_full;

   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_mem[push_idx] <= pc_plus1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_ADDR;
         sp        <= '0;
         stack_err <= 1'b0;
      end else if (enable) begin
         if (state == FETCH) begin
            state <= EXEC;
         end else begin
            state <= FETCH;
            if (ret) begin
               if (!stack_empty) begin
                  pc <= stack_mem[pop_idx];
                  sp <= sp - SP_W'(1);
               end else begin
                  pc        <= pc_plus1;
                  stack_err <= 1'b1;
               end
            end else if (call) begin
               // Overflowing call neither pushes nor jumps; it just steps on.
               if (!stack_full) begin
                  pc <= load_value;
                  sp <= sp + SP_W'(1);
               end else begin
                  pc        <= pc_plus1;
                  stack_err <= 1'b1;
               end
            end else if (load) begin
               pc <= load_value;
            end else if (inc) begin
               pc <= pc_plus1;
            end
         end
      end
   end

endmodule
